mem_loader: RTL

MEM_LOADER -- requirements
Module: mem_loader

---
 rtl/mem_loader_pkg.sv | 16 +
 rtl/mem_loader_edge.sv | 13 +
 rtl/mem_loader.sv | 57 +++++
 3 files changed

// File: rtl/mem_loader_pkg.sv
// mem_loader_pkg: loader state encodings, LED status bit positions and status packing helper
package mem_loader_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, GET_LO = 2'd1, GET_HI = 2'd2, WRITE = 2'd3} state_t;
  localparam int ST_STATE_LSB = 6;
  localparam int ST_WRAPPED   = 5;
  localparam int ST_COUNT_LSB = 0;
  localparam int COUNT_W      = 4;
  function automatic logic [7:0] pack_status(state_t s, logic wrapped, logic [COUNT_W-1:0] cnt);
    logic [7:0] r;
    r = '0;
    r[ST_STATE_LSB +: 2] = s;
    r[ST_WRAPPED] = wrapped;
    r[ST_COUNT_LSB +: COUNT_W] = cnt;
    return r;
  endfunction
endpackage

// File: rtl/mem_loader_edge.sv
// edge_detect: registered-history rising-edge detector (clk, reset, din -> rise)
module edge_detect (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic rise
);
  logic prev;
  always_ff @(posedge clk or posedge reset)
    if (reset) prev <= 1'b0;
    else prev <= din;
  assign rise = din & ~prev;
endmodule

// File: rtl/mem_loader.sv
// mem_loader: switch/step-button RAM word loader (clk, reset, load_en, step, sw -> addr, din, we, active, status)
module mem_loader
  import mem_loader_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_en,
  input  logic              step,
  input  logic [DATA_W/2-1:0] sw,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] din,
  output logic              we,
  output logic              active,
  output logic [7:0]        status
);
  localparam int B = DATA_W / 2;
  state_t state, state_nx;
  logic rise, wrapped;
  logic [COUNT_W-1:0] word_count;
  edge_detect u_edge (.clk(clk), .reset(reset), .din(step), .rise(rise));
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    state_nx = state == IDLE   ? (load_en ? GET_LO : IDLE) :
               !load_en        ? IDLE :
               state == GET_LO ? (rise ? GET_HI : GET_LO) :
               state == GET_HI ? (rise ? WRITE : GET_HI) : GET_LO;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      addr       <= '0;
      din        <= '0;
      wrapped    <= 1'b0;
      word_count <= '0;
    end else if (state == IDLE) begin
      if (load_en) begin
        addr       <= '0;
        wrapped    <= 1'b0;
        word_count <= '0;
      end
    end else if (state == WRITE) begin
      addr       <= addr + 1'b1;
      word_count <= word_count + 1'b1;
      if (&addr) wrapped <= 1'b1;
    end else if (load_en && rise) begin
      if (state == GET_LO) din[B-1:0] <= sw;
      else din[DATA_W-1:B] <= sw;
    end
  assign we = state == WRITE;
  assign active = state != IDLE;
  assign status = pack_status(state, wrapped, word_count);
endmodule
